friscv_apb_arbiter: RTL
=======================

// Module: friscv_apb_arbiter
// PURPOSE
// - Shares one APB-style slave port (UART control/status, TX/RX FIFO regs) between NB_REQ masters (e.g. core LSU, debug loader).
// - Round-robin arbitration, one transaction at a time, grant held until slave ready.
// - Sits between the requesters and the peripheral's mst_* port; transparent to both protocols.
// PARAMETERS
// - NB_REQ  2   number of requesters (2..8)
// - ADDRW   16  address width
// - XLEN    32  data width
// PORTS
// - aclk       in   1             clock; single clock domain
// - areset     in   1             asynchronous reset, active-high
// - srst       in   1             synchronous reset, active-high
// - req_en     in   NB_REQ        per-requester request, held until its req_ready
// - req_wr     in   NB_REQ        1=write 0=read
// - req_addr   in   NB_REQ*ADDRW  flattened, requester i at [i*ADDRW+:ADDRW]
// - req_wdata  in   NB_REQ*XLEN   flattened write data
// - req_strb   in   NB_REQ*XLEN/8 flattened byte strobes
// - req_rdata  out  XLEN          read data, broadcast to all requesters
// - req_ready  out  NB_REQ        one-cycle completion pulse to granted requester
// - slv_en     out  1             to peripheral mst_en
// - slv_wr     out  1             to peripheral mst_wr
// - slv_addr   out  ADDRW         to peripheral mst_addr
// - slv_wdata  out  XLEN          to peripheral mst_wdata
// - slv_strb   out  XLEN/8        to peripheral mst_strb
// - slv_rdata  in   XLEN          from peripheral mst_rdata
// - slv_ready  in   1             from peripheral mst_ready (one-cycle pulse)
// - grant      out  NB_REQ        one-hot current owner, 0 when idle
// BEHAVIOUR
// - Reset (areset async or srst sync): fsm=IDLE, rr_ptr=0, grant=0; slv_en=0, req_ready=0.
// - FSM IDLE: if |req_en, pick first i with req_en[i] searching rr_ptr, rr_ptr+1, .. mod NB_REQ;
//   register grant=onehot(i), -> BUSY. No request -> stay IDLE.
// - FSM BUSY: slv_en = req_en[g]; slv_wr/addr/wdata/strb = requester g fields (comb mux of grant).
//   req_ready[g] = slv_ready (comb); other req_ready bits 0. req_rdata = slv_rdata always.
//   slv_ready=1 -> rr_ptr=(g+1) mod NB_REQ, -> RELEASE.
//   req_en[g] drops before slv_ready (protocol violation) -> rr_ptr=g+1, -> IDLE, no ready issued.
// - FSM RELEASE: slv_en=0 one cycle (peripheral clears its ready), grant cleared -> IDLE.
// - Latency: request to slv_en = 1 cycle; slv_ready to req_ready = 0 cycles;
//   min 3 cycles per transaction (IDLE, BUSY with same-cycle ready, RELEASE).
// - Requester must drop req_en the cycle after req_ready; re-assert = new request, re-arbitrated.
// - Blocking slave accesses (TX full, RX empty) hold grant indefinitely; others stall; no timeout.
// - Non-granted requesters see req_ready=0; their inputs are ignored.
// - slv_ready outside BUSY ignored; rr_ptr wraps NB_REQ-1 -> 0.
// - Reset mid-BUSY: slave transaction abandoned, slv_en low immediately on areset.
// TESTING
// - req0 write addr 0 data 0x1 strb 0x1, slv_ready after 1 cycle -> slv_en 1 cycle after req, req_ready[0] pulse, grant back to 0.
// - req0 and req1 asserted same cycle after reset -> req0 served first, then req1; repeat -> order 0,1,0,1.
// - req1 read addr 3, slv_ready held off 20 cycles, req0 requests meanwhile -> req0 waits, served after req1 RELEASE, req_rdata=slv_rdata on req_ready.
// - req0 back-to-back requests with req1 idle -> gaps of exactly RELEASE+IDLE between slv_en windows.
// - areset asserted mid-BUSY -> slv_en, req_ready, grant 0 immediately; after release rr_ptr=0.
// - req_en[g] dropped mid-BUSY -> FSM IDLE next cycle, no req_ready pulse, next requester granted.

Source files
------------

// File: rtl/friscv_apb_arbiter_if.sv
// friscv_apb_arbiter_if
//   Bundles the signals between NB_REQ APB-style requesters, the shared
//   peripheral port and the arbiter that sits in between.
//   master modport : the arbiter's view (takes requests and slave responses,
//                    drives the slave command, completion pulses and grant).
//   slave modport  : the environment's view (requesters plus peripheral).
//   Signals
//     req_en/req_wr        per-requester request and direction (1=write)
//     req_addr/wdata/strb  flattened per-requester fields, requester i at
//                          [i*W +: W]
//     req_rdata/req_ready  read data broadcast, one-cycle completion pulse
//     slv_*                command to / response from the peripheral
//     grant                one-hot current owner, 0 when idle
interface friscv_apb_arbiter_if #(
    parameter int NB_REQ = 2,
    parameter int ADDRW  = 16,
    parameter int XLEN   = 32
);
    logic [NB_REQ-1:0]          req_en;
    logic [NB_REQ-1:0]          req_wr;
    logic [NB_REQ*ADDRW-1:0]    req_addr;
    logic [NB_REQ*XLEN-1:0]     req_wdata;
    logic [NB_REQ*XLEN/8-1:0]   req_strb;
    logic [XLEN-1:0]            req_rdata;
    logic [NB_REQ-1:0]          req_ready;
    logic                       slv_en;
    logic                       slv_wr;
    logic [ADDRW-1:0]           slv_addr;
    logic [XLEN-1:0]            slv_wdata;
    logic [XLEN/8-1:0]          slv_strb;
    logic [XLEN-1:0]            slv_rdata;
    logic                       slv_ready;
    logic [NB_REQ-1:0]          grant;

    modport master (
        input  req_en, req_wr, req_addr, req_wdata, req_strb,
        input  slv_rdata, slv_ready,
        output req_rdata, req_ready,
        output slv_en, slv_wr, slv_addr, slv_wdata, slv_strb,
        output grant
    );

    modport slave (
        output req_en, req_wr, req_addr, req_wdata, req_strb,
        output slv_rdata, slv_ready,
        input  req_rdata, req_ready,
        input  slv_en, slv_wr, slv_addr, slv_wdata, slv_strb,
        input  grant
    );
endinterface

// File: rtl/friscv_apb_arbiter.sv
// friscv_apb_arbiter
//   Shares one APB-style slave port between NB_REQ masters. Round-robin
//   arbitration, one transaction at a time; the grant is held until the
//   slave answers with slv_ready, then a one-cycle RELEASE lets the
//   peripheral clear its ready before the next owner is chosen.
//   Ports
//     aclk    clock
//     areset  asynchronous reset, active-high
//     srst    synchronous reset, active-high
//     bus     friscv_apb_arbiter_if master modport (requesters + slave side)
module friscv_apb_arbiter #(
    parameter int NB_REQ = 2,
    parameter int ADDRW  = 16,
    parameter int XLEN   = 32
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   srst,
    friscv_apb_arbiter_if.master   bus
);

    localparam int PTRW = $clog2(NB_REQ);

    typedef logic [PTRW-1:0] ptr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state;
    ptr_t              rr_ptr;
    ptr_t              gidx;
    logic [NB_REQ-1:0] grant_q;

    logic              pick_found;
    ptr_t              pick_idx;
    logic [NB_REQ-1:0] pick_onehot;
    logic              owner_en;
    logic              busy;

    // Modulo increment so non power-of-two NB_REQ still wraps at NB_REQ-1.
    function automatic ptr_t ptr_inc(input ptr_t p);
        if (int'(p) == NB_REQ - 1) begin
            return '0;
        end
        return p + ptr_t'(1);
    endfunction

    // Round-robin search starting at rr_ptr: first active request wins.
    always_comb begin
        int cand;
        cand        = 0;
        pick_found  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NB_REQ) begin
                cand = cand - NB_REQ;
            end
            if (!pick_found && bus.req_en[cand]) begin
                pick_found = 1'b1;
                pick_idx   = ptr_t'(cand);
            end
        end
        if (pick_found) begin
            pick_onehot[pick_idx] = 1'b1;
        end
    end

    // Arbitration FSM. grant stays set through RELEASE and is cleared on
    // the way back to IDLE. An owner dropping req_en before the slave
    // answers abandons the transaction without a completion pulse.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gidx    <= '0;
            grant_q <= '0;
        end else if (srst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gidx    <= '0;
            grant_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gidx    <= pick_idx;
                        grant_q <= pick_onehot;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (!owner_en) begin
                        rr_ptr  <= ptr_inc(gidx);
                        grant_q <= '0;
                        state   <= IDLE;
                    end else if (bus.slv_ready) begin
                        rr_ptr  <= ptr_inc(gidx);
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    grant_q <= '0;
                    state   <= IDLE;
                end
                default: begin
                    grant_q <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign busy     = (state == BUSY);
    assign owner_en = bus.req_en[gidx];

    // Slave command is a plain mux of the owner's fields; slv_en follows the
    // owner's req_en so a withdrawn request is never presented to the slave.
    assign bus.slv_en    = busy & owner_en;
    assign bus.slv_wr    = bus.req_wr[gidx];
    assign bus.slv_addr  = bus.req_addr[int'(gidx)*ADDRW +: ADDRW];
    assign bus.slv_wdata = bus.req_wdata[int'(gidx)*XLEN +: XLEN];
    assign bus.slv_strb  = bus.req_strb[int'(gidx)*(XLEN/8) +: XLEN/8];

    // Completion is combinational from slv_ready so the owner sees it in the
    // same cycle; a ready arriving outside an active BUSY cycle is dropped.
    assign bus.req_ready = (bus.slv_en && bus.slv_ready) ? grant_q : '0;
    assign bus.req_rdata = bus.slv_rdata;
    assign bus.grant     = grant_q;

endmodule
